// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with stall hold, flush-to-bubble and a tracked valid bit.
// Defining PIPE_PERF_EN adds saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int unsigned          DATA_W     = 128,
  parameter int unsigned          CTRL_W     = 16,
  parameter int unsigned          INSTR_W    = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR  = 32'h00000013,
  parameter bit                   CLEAR_DATA = 1'b1,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               ValidIn,
  input  logic [DATA_W-1:0]  DataIn,
  input  logic [CTRL_W-1:0]  CtrlIn,
  input  logic [INSTR_W-1:0] InstrIn,
  input  logic               CntClear,
  output logic               ValidOut,
  output logic [DATA_W-1:0]  DataOut,
  output logic [CTRL_W-1:0]  CtrlOut,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [CNT_W-1:0]   StallCount,
  output logic [CNT_W-1:0]   BubbleCount
);

  // Every path that clears ValidOut also clears CtrlOut and forces the NOP word,
  // so no write enable can escape through a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      ValidOut <= 1'b0;
      DataOut  <= '0;
      CtrlOut  <= '0;
      InstrOut <= NOP_INSTR;
    end else if (Flush) begin
      ValidOut <= 1'b0;
      CtrlOut  <= '0;
      InstrOut <= NOP_INSTR;
      if (CLEAR_DATA) DataOut <= '0;
    end else if (!Stall) begin
      ValidOut <= ValidIn;
      if (ValidIn) begin
        DataOut  <= DataIn;
        CtrlOut  <= CtrlIn;
        InstrOut <= InstrIn;
      end else begin
        DataOut  <= CLEAR_DATA ? '0 : DataIn;
        CtrlOut  <= '0;
        InstrOut <= NOP_INSTR;
      end
    end
  end

`ifdef PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic stall_evt;
  logic bubble_evt;

  // A stall only counts while a real instruction is being held.
  assign stall_evt  = Stall && !Flush && ValidOut;
  assign bubble_evt = Flush || (!Stall && !ValidIn);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCount  <= '0;
      BubbleCount <= '0;
    end else if (CntClear) begin
      StallCount  <= '0;
      BubbleCount <= '0;
    end else begin
      if (stall_evt && (StallCount != CNT_MAX))   StallCount  <= StallCount + 1'b1;
      if (bubble_evt && (BubbleCount != CNT_MAX)) BubbleCount <= BubbleCount + 1'b1;
    end
  end
`else
  logic unused_cnt_clear;

  assign unused_cnt_clear = CntClear;
  assign StallCount       = '0;
  assign BubbleCount      = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked every cycle against a rule-level model, on two CLEAR_DATA variants.
module tb_pipe_stage_reg;

  localparam int          DW   = 128;
  localparam int          CW   = 16;
  localparam int          IW   = 32;
  localparam int          CNTW = 4;
  localparam logic [31:0] NOP  = 32'h00000013;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          Stall, Flush, ValidIn, CntClear;
  logic [DW-1:0] DataIn;
  logic [CW-1:0] CtrlIn;
  logic [IW-1:0] InstrIn;

  logic            va, vb;
  logic [DW-1:0]   da, db;
  logic [CW-1:0]   ca, cb;
  logic [IW-1:0]   ia, ib;
  logic [CNTW-1:0] sa, sb, ba, bb;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(NOP),
                   .CLEAR_DATA(1'b1), .CNT_W(CNTW)) dut_a (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .DataIn(DataIn), .CtrlIn(CtrlIn), .InstrIn(InstrIn), .CntClear(CntClear),
    .ValidOut(va), .DataOut(da), .CtrlOut(ca), .InstrOut(ia),
    .StallCount(sa), .BubbleCount(ba));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .INSTR_W(IW), .NOP_INSTR(NOP),
                   .CLEAR_DATA(1'b0), .CNT_W(CNTW)) dut_b (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush), .ValidIn(ValidIn),
    .DataIn(DataIn), .CtrlIn(CtrlIn), .InstrIn(InstrIn), .CntClear(CntClear),
    .ValidOut(vb), .DataOut(db), .CtrlOut(cb), .InstrOut(ib),
    .StallCount(sb), .BubbleCount(bb));

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Rule-level model: what the stage must hold after each edge.
  bit            m_valid;
  logic [CW-1:0] m_ctrl;
  logic [IW-1:0] m_instr;
  logic [DW-1:0] m_data_a, m_data_b;
  int            m_stalls, m_bubbles;
  bit            e_hold, e_bubble, e_was_valid;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0; m_ctrl = '0; m_instr = NOP;
      m_data_a = '0; m_data_b = '0; m_stalls = 0; m_bubbles = 0;
    end else begin
      e_hold      = Stall && !Flush;
      e_bubble    = Flush || (!Stall && !ValidIn);
      e_was_valid = m_valid;
      if (!e_hold) begin
        m_valid  = !e_bubble;
        m_ctrl   = e_bubble ? '0 : CtrlIn;
        m_instr  = e_bubble ? NOP : InstrIn;
        m_data_a = e_bubble ? '0 : DataIn;
        if (!Flush) m_data_b = DataIn;
      end
      if (CntClear) begin
        m_stalls = 0; m_bubbles = 0;
      end else begin
        if (e_hold && e_was_valid) m_stalls  = (m_stalls  < CMAX) ? m_stalls + 1  : CMAX;
        if (e_bubble)              m_bubbles = (m_bubbles < CMAX) ? m_bubbles + 1 : CMAX;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a_valid", DW'(va), DW'(m_valid));
      check("b_valid", DW'(vb), DW'(m_valid));
      check("a_ctrl",  DW'(ca), DW'(m_ctrl));
      check("b_ctrl",  DW'(cb), DW'(m_ctrl));
      check("a_instr", DW'(ia), DW'(m_instr));
      check("b_instr", DW'(ib), DW'(m_instr));
      check("a_data",  da, m_data_a);
      check("b_data",  db, m_data_b);
      check("a_stall_cnt",  DW'(sa), PERF ? DW'(m_stalls)  : '0);
      check("b_stall_cnt",  DW'(sb), PERF ? DW'(m_stalls)  : '0);
      check("a_bubble_cnt", DW'(ba), PERF ? DW'(m_bubbles) : '0);
      check("b_bubble_cnt", DW'(bb), PERF ? DW'(m_bubbles) : '0);
    end
  end

  // One edge of stimulus; returns 1 time unit after the rising edge.
  task automatic cycle(input bit st, input bit fl, input bit vi, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic [IW-1:0] ins, input bit clr);
    @(negedge clk);
    Stall = st; Flush = fl; ValidIn = vi; DataIn = d; CtrlIn = c; InstrIn = ins; CntClear = clr;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] d1;

  initial begin
    reset = 1'b1;
    Stall = 1'b0; Flush = 1'b0; ValidIn = 1'b1; CntClear = 1'b0;
    DataIn = '1; CtrlIn = 16'hABCD; InstrIn = 32'h12345678;

    // Load real content, then assert reset mid-cycle: outputs must clear at once.
    cycle(0, 0, 1, '1, 16'hABCD, 32'h12345678, 0);
    cycle(0, 0, 1, '1, 16'hABCD, 32'h12345678, 0);
    check("pre_reset_valid", DW'(va), DW'(1));
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_valid", DW'(va), DW'(0));
    check("rst_ctrl",  DW'(ca), DW'(0));
    check("rst_instr", DW'(ia), DW'(32'h00000013));
    check("rst_data_a", da, '0);
    check("rst_data_b", db, '0);
    check("rst_bubble_cnt", DW'(ba), DW'(0));
    cmp_en = 1'b1;
    @(negedge clk);
    reset = 1'b1;

    cycle(0, 0, 1, DW'(32'h11), 16'h0001, 32'h00A00093, 0);
    check("first_instr", DW'(ia), DW'(32'h00A00093));
    check("first_valid", DW'(va), DW'(1));

    // Stall hold
    d1 = {32'hCAFE0000, 64'h0, 32'h0000F00D};
    cycle(0, 0, 1, d1, 16'h00FF, 32'h00100113, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 1, DW'(32'h55), 16'h1234, 32'h00200193, 0);
      check("stall_hold_ctrl", DW'(ca), DW'(16'h00FF));
    end
    check("stall_hold_data", db, d1);
    cycle(0, 0, 1, d1, 16'h1234, 32'h00300213, 0);
    check("stall_release_ctrl", DW'(ca), DW'(16'h1234));

    // Flush beats stall
    cycle(1, 1, 1, DW'(32'h77), 16'h7777, 32'h00400293, 0);
    check("flush_valid", DW'(va), DW'(0));
    check("flush_ctrl",  DW'(ca), DW'(0));
    check("flush_instr", DW'(ia), DW'(32'h00000013));
    check("flush_data_hold_b", db, d1);
    check("flush_data_clear_a", da, '0);

    // Upstream bubble
    cycle(0, 0, 0, DW'(32'hDEADBEEF), 16'hFFFF, 32'h00500313, 0);
    check("ubub_ctrl",  DW'(ca), DW'(0));
    check("ubub_instr", DW'(ia), DW'(32'h00000013));
    check("ubub_valid", DW'(va), DW'(0));
    check("ubub_data_a", da, '0);
    check("ubub_data_b", db, DW'(32'hDEADBEEF));

    // Counters: 3 stalls + 20 stalls saturate at 15; bubbles so far: 2
    cycle(0, 0, 1, DW'(32'h99), 16'h0F0F, 32'h00600393, 0);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, '0, '0, '0, 0);
    check("stall_cnt_sat", DW'(sa), PERF ? DW'(15) : '0);
    check("bubble_cnt_2",  DW'(ba), PERF ? DW'(2)  : '0);
    cycle(0, 1, 1, '0, '0, '0, 1);
    check("clr_beats_flush", DW'(ba), DW'(0));
    check("clr_stall_cnt",   DW'(sa), DW'(0));

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        cycle($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < 70,
              {$urandom, $urandom, $urandom, $urandom},
              CW'($urandom), $urandom, $urandom_range(0, 99) < 4);
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
